uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, UART_Clk cycles per serial bit (even, >=4).
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame (LSB first).
REQ-003 SHALL have port UART_Clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port RESET_N, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have port UART_RXD, input, 1, asynchronous serial line; idle high.
REQ-006 SHALL have port rx_data, output, DATA_BITS, last correctly framed byte.
REQ-007 SHALL have port rx_valid, output, 1, one-cycle pulse when rx_data updates.
REQ-008 SHALL have port frame_err, output, 1, one-cycle pulse on bad stop bit.
REQ-009 SHALL have port rx_busy, output, 1, high while any state other than IDLE.

Function
REQ-010 SHALL pass UART_RXD through a 2-flop synchronizer; all decisions use the synchronized value (rxs).
REQ-011 SHALL implement the FSM states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-012 In IDLE, rxs==0 SHALL move the FSM to START and clear the bit-timer.
REQ-013 In START, the FSM SHALL sample rxs at timer==CLKS_PER_BIT/2-1; 0 -> DATA, 1 -> IDLE (glitch rejected, no pulse).
REQ-014 In DATA, the FSM SHALL sample every CLKS_PER_BIT cycles after the start sample and shift each sample in LSB first; after DATA_BITS samples -> STOP.
REQ-015 In STOP, the FSM SHALL sample CLKS_PER_BIT cycles after the last data sample.
REQ-016 A stop-bit sample of 1 SHALL load rx_data from the shift register, pulse rx_valid the next cycle and move to IDLE.
REQ-017 A stop-bit sample of 0 SHALL leave rx_data unchanged, pulse frame_err the next cycle and move to WAIT_IDLE.
REQ-018 WAIT_IDLE SHALL hold until rxs==1 and then go to IDLE (a break condition produces exactly one frame_err).
REQ-019 rx_valid and frame_err SHALL never be high in the same cycle and SHALL be exactly one cycle wide.
REQ-020 A falling edge arriving in the cycle of the IDLE return SHALL be accepted, so back-to-back frames need no gap.
REQ-021 The bit-timer SHALL be $clog2(CLKS_PER_BIT) bits wide and wrap from CLKS_PER_BIT-1 to 0.
REQ-022 The bit index SHALL be $clog2(DATA_BITS+1) bits wide.
REQ-023 Latency SHALL be fixed: rx_valid rises 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT cycles after the UART_RXD falling edge (154 at defaults).

Reset
REQ-024 While RESET_N==0 at a clock edge: state=IDLE, rx_data=0, rx_valid=0, frame_err=0, rx_busy=0, timers=0, synchronizer flops=1.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no rx_valid/frame_err pulse; after release, reception resumes on the next falling edge.

Structure
REQ-026 The FSM state enum and the sampling-point constant (CLKS_PER_BIT/2-1) SHALL live in the shared package uart_pkg, shared with the transmitter.
REQ-027 The 2-flop synchronizer SHALL be the single sub-module, sync2 (1-bit, reset value 1).
REQ-028 The RTL SHALL be a single always block for the FSM plus the sync2 instance; there SHALL be no latches and no combinational outputs.

Verification
REQ-029 Defaults, frame 0x41 (start, 1,0,0,0,0,0,1,0, stop) -> rx_data=0x41, one rx_valid pulse 154 cycles after the falling edge, frame_err=0.
REQ-030 Frames 0x41, 0x42, 0x0A, 0x0D sent back-to-back with no idle gap -> four rx_valid pulses with those values in order.
REQ-031 A 5-cycle low glitch on the idle line -> FSM returns to IDLE, no rx_valid, no frame_err, rx_data unchanged.
REQ-032 Frame 0x55 with stop bit forced 0, line then held low for 40 bit times -> exactly one frame_err pulse, rx_data keeps its prior value, next valid frame 0xA5 received correctly.
REQ-033 RESET_N pulled low for 1 cycle during data bit 4 of a frame -> no pulse for that frame, all outputs at reset values, following frame 0x3C received.
REQ-034 CLKS_PER_BIT=10 with a transmitter clock 3% fast and 3% slow -> frame 0xFF and frame 0x00 both received without error.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and the mid-bit sampling point.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_state_e;

    // Bit-timer value at which the start bit is checked (middle of the bit).
    function automatic int mid_sample(input int clks_per_bit);
        return clks_per_bit / 2 - 1;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous line, resets to 1 (line idle).
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of a synchronized serial line, LSB first,
// with registered valid / framing-error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 UART_Clk,
    input  logic                 RESET_N,
    input  logic                 UART_RXD,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] T_MID  = TW'(mid_sample(CLKS_PER_BIT));
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    logic rxs;

    uart_state_e          state_q;
    logic [TW-1:0]        timer_q;
    logic [BW-1:0]        bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 rx_busy_q;

    sync2 u_sync2 (
        .clk   (UART_Clk),
        .rst_n (RESET_N),
        .d     (UART_RXD),
        .q     (rxs)
    );

    always_ff @(posedge UART_Clk) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rx_busy_q   <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_q   <= START;
                        timer_q   <= '0;
                        rx_busy_q <= 1'b1;
                    end
                end
                START: begin
                    if (timer_q == T_MID) begin
                        timer_q   <= '0;
                        bit_idx_q <= '0;
                        if (rxs) begin
                            state_q   <= IDLE;
                            rx_busy_q <= 1'b0;
                        end else begin
                            state_q <= DATA;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                DATA: begin
                    if (timer_q == T_LAST) begin
                        timer_q <= '0;
                        shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
                        if (bit_idx_q == B_LAST) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                STOP: begin
                    if (timer_q == T_LAST) begin
                        timer_q <= '0;
                        if (rxs) begin
                            rx_data_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                            state_q    <= IDLE;
                            rx_busy_q  <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_IDLE;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                // A held-low line (break) stays here so only one error fires.
                WAIT_IDLE: begin
                    if (rxs) begin
                        state_q   <= IDLE;
                        rx_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    rx_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = rx_busy_q;

endmodule
